// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
//   - Bit positions of every field in the 36-bit core instruction word.
//   - The IDLE instruction word (both SRAMs disabled, read mode, all strobes 0).
//   - The sequencer state enumeration.
//   - A packed field bundle used to hand named fields to inst_pack.
package inst_sequencer_pkg;

    localparam int INST_W   = 36;
    localparam int INST_A_W = 11;  // width of both SRAM address fields in the word

    localparam int BIT_MODE      = 35;
    localparam int BIT_DATA_MODE = 34;
    localparam int BIT_ACC       = 33;
    localparam int BIT_CEN_PMEM  = 32;
    localparam int BIT_WEN_PMEM  = 31;
    localparam int A_PMEM_LSB    = 20;
    localparam int BIT_CEN_XMEM  = 19;
    localparam int BIT_WEN_XMEM  = 18;
    localparam int A_XMEM_LSB    = 7;
    localparam int BIT_OFIFO_RD  = 6;
    localparam int BIT_IFIFO_WR  = 5;
    localparam int BIT_IFIFO_RD  = 4;
    localparam int BIT_L0_RD     = 3;
    localparam int BIT_L0_WR     = 2;
    localparam int BIT_EXECUTE   = 1;
    localparam int BIT_LOAD      = 0;

    localparam logic [INST_W-1:0] IDLE_WORD = 36'h1800C0000;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        KLOAD,
        GAP,
        EXEC,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic                mode;
        logic                data_mode;
        logic                acc;
        logic                cen_pmem;
        logic                wen_pmem;
        logic [INST_A_W-1:0] a_pmem;
        logic                cen_xmem;
        logic                wen_xmem;
        logic [INST_A_W-1:0] a_xmem;
        logic                ofifo_rd;
        logic                ififo_wr;
        logic                ififo_rd;
        logic                l0_rd;
        logic                l0_wr;
        logic                execute;
        logic                load;
    } inst_fields_t;

    // Field values that reproduce IDLE_WORD.
    function automatic inst_fields_t idle_fields();
        inst_fields_t f;
        f          = '0;
        f.cen_pmem = 1'b1;
        f.wen_pmem = 1'b1;
        f.cen_xmem = 1'b1;
        f.wen_xmem = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/inst_sequencer_pack.sv
// inst_pack: combinationally places named instruction fields at their
// positions in the core's 36-bit instruction word.
//   f    : input  field bundle
//   inst : output assembled instruction word
module inst_pack
    import inst_sequencer_pkg::*;
(
    input  inst_fields_t      f,
    output logic [INST_W-1:0] inst
);

    always_comb begin
        inst                                  = '0;
        inst[BIT_MODE]                        = f.mode;
        inst[BIT_DATA_MODE]                   = f.data_mode;
        inst[BIT_ACC]                         = f.acc;
        inst[BIT_CEN_PMEM]                    = f.cen_pmem;
        inst[BIT_WEN_PMEM]                    = f.wen_pmem;
        inst[A_PMEM_LSB +: INST_A_W]          = f.a_pmem;
        inst[BIT_CEN_XMEM]                    = f.cen_xmem;
        inst[BIT_WEN_XMEM]                    = f.wen_xmem;
        inst[A_XMEM_LSB +: INST_A_W]          = f.a_xmem;
        inst[BIT_OFIFO_RD]                    = f.ofifo_rd;
        inst[BIT_IFIFO_WR]                    = f.ififo_wr;
        inst[BIT_IFIFO_RD]                    = f.ififo_rd;
        inst[BIT_L0_RD]                       = f.l0_rd;
        inst[BIT_L0_WR]                       = f.l0_wr;
        inst[BIT_EXECUTE]                     = f.execute;
        inst[BIT_LOAD]                        = f.load;
    end

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: drives one weight-stationary pass of the core.
// WLOAD streams row weight vectors from weight SRAM into L0, KLOAD moves
// them into the PE array, GAP idles one cycle, EXEC streams n_act
// activation vectors, DRAIN reads the output FIFO n_act times, FIN pulses done.
//   clk, reset        : clock, synchronous active-high reset
//   start             : pass request (IDLE only) with w_base, x_base, n_act, acc_en
//   ofifo_valid       : output FIFO has data
//   inst              : registered instruction word to the core
//   busy, done        : not-IDLE flag, one-cycle completion pulse
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] x_base,
    input  logic [addr_w-1:0] n_act,
    input  logic              acc_en,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    // One spare bit so k can reach n_act and row without overflow.
    localparam int k_w = addr_w + 1;
    localparam logic [k_w-1:0] row_k    = k_w'(row);
    localparam logic [k_w-1:0] col_last = k_w'(col - 1);
    localparam logic [k_w-1:0] k_one    = k_w'(1);

    state_t            state_q, state_d;
    logic [k_w-1:0]    k_q, k_d;
    logic [addr_w-1:0] w_base_q, w_base_d;
    logic [addr_w-1:0] x_base_q, x_base_d;
    logic [addr_w-1:0] n_act_q, n_act_d;
    logic              acc_q, acc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    inst_fields_t      fields;
    logic [k_w-1:0]    n_act_k_q, n_act_k_d;
    logic [addr_w-1:0] a_pmem_sum, a_xmem_sum;

    assign n_act_k_q = {1'b0, n_act_q};
    assign n_act_k_d = {1'b0, n_act_d};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            n_act_q  <= '0;
            acc_q    <= 1'b0;
            inst_q   <= IDLE_WORD;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            w_base_q <= w_base_d;
            x_base_q <= x_base_d;
            n_act_q  <= n_act_d;
            acc_q    <= acc_d;
            inst_q   <= inst_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        n_act_d  = n_act_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WLOAD;
                    k_d      = '0;
                    w_base_d = w_base;
                    x_base_d = x_base;
                    n_act_d  = n_act;
                    acc_d    = acc_en;
                end
            end
            WLOAD: begin
                if (k_q == row_k) begin
                    state_d = KLOAD;
                    k_d     = '0;
                end else begin
                    k_d = k_q + k_one;
                end
            end
            KLOAD: begin
                if (k_q == col_last) begin
                    state_d = GAP;
                    k_d     = '0;
                end else begin
                    k_d = k_q + k_one;
                end
            end
            GAP: begin
                state_d = (n_act_q != '0) ? EXEC : FIN;
                k_d     = '0;
            end
            EXEC: begin
                if (k_q == n_act_k_q) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + k_one;
                end
            end
            DRAIN: begin
                // k counts FIFO reads; leave on the cycle the last one issues.
                if (ofifo_valid) begin
                    k_d = k_q + k_one;
                    if ((k_q + k_one) == n_act_k_q) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Outputs. The word is built from next-state values so that, once
    // registered, it lines up with the cycles the FSM spends in each state.
    always_comb begin
        a_pmem_sum = w_base_d + k_d[addr_w-1:0];
        a_xmem_sum = x_base_d + k_d[addr_w-1:0];
        fields     = idle_fields();
        if (state_d != IDLE && state_d != FIN) begin
            fields.mode = 1'b1;
            fields.acc  = acc_d;
        end
        case (state_d)
            WLOAD: begin
                fields.data_mode = 1'b1;
                if (k_d < row_k) begin
                    fields.cen_pmem = 1'b0;
                    fields.a_pmem   = INST_A_W'(a_pmem_sum);
                end
                // SRAM data arrives one cycle after the address.
                fields.l0_wr = (k_d != '0);
            end
            KLOAD: begin
                fields.data_mode = 1'b1;
                fields.l0_rd     = 1'b1;
                fields.load      = 1'b1;
            end
            EXEC: begin
                if (k_d < n_act_k_d) begin
                    fields.cen_xmem = 1'b0;
                    fields.a_xmem   = INST_A_W'(a_xmem_sum);
                end
                if (k_d != '0) begin
                    fields.l0_wr   = 1'b1;
                    fields.l0_rd   = 1'b1;
                    fields.execute = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // FIFO reads follow ofifo_valid within the same cycle, so that bit
        // bypasses the output register; everything else is registered.
        inst               = inst_q;
        inst[BIT_OFIFO_RD] = (state_q == DRAIN) && ofifo_valid;
        busy               = (state_q != IDLE);
        done               = (state_q == FIN);
    end

    inst_pack u_inst_pack (
        .f    (fields),
        .inst (inst_d)
    );

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;

    localparam logic [35:0] IDLE_W = 36'h1800C0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] w_base;
    logic [10:0] x_base;
    logic [10:0] n_act;
    logic        acc_en;
    logic        ofifo_valid;
    logic [35:0] inst;
    logic        busy;
    logic        done;

    inst_sequencer #(.row(8), .col(8), .addr_w(11)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .x_base      (x_base),
        .n_act       (n_act),
        .acc_en      (acc_en),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_miss;

    // Per-pass observations
    int          pmem_q[$];
    int          xmem_q[$];
    int          first_load, n_l0wr_w, n_load, n_exec, n_ofifo;
    int          n_done, done_cyc, post_busy, bad;
    logic [63:0] rd_log;
    logic [35:0] inst_at_rst;
    logic        busy_at_rst, done_at_rst;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // vmode 0: ofifo_valid tied 1; vmode 1: pattern 1,0,0,1,1 from cycle 23.
    task automatic run_pass(input int wb, input int xb, input int na, input bit acc,
                            input int vmode, input int restart_cyc, input int reset_cyc);
        logic [4:0] pat;
        int idx;
        pat = 5'b11001;
        pmem_q.delete();
        xmem_q.delete();
        first_load = -1; n_l0wr_w = 0; n_load = 0; n_exec = 0; n_ofifo = 0;
        n_done = 0; done_cyc = -1; post_busy = 0; bad = 0; rd_log = '0;
        inst_at_rst = '0; busy_at_rst = 1'b1; done_at_rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = (c == 0) || (c == restart_cyc);
            if (c == 0) begin
                w_base = 11'(wb); x_base = 11'(xb); n_act = 11'(na); acc_en = acc;
            end else begin
                w_base = (c == restart_cyc) ? 11'd999 : 11'd777;
                x_base = 11'd555; n_act = 11'd9; acc_en = ~acc;
            end
            reset = (c == reset_cyc);
            if (vmode == 0) begin
                ofifo_valid = 1'b1;
            end else begin
                idx = c - 23;
                ofifo_valid = (idx >= 0 && idx < 5) ? pat[idx] : 1'b0;
            end
            #1;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy && ((done_cyc >= 0 && c > done_cyc) || (reset_cyc >= 0 && c > reset_cyc)))
                post_busy++;
            if (reset_cyc >= 0 && c == reset_cyc + 1) begin
                inst_at_rst = inst; busy_at_rst = busy; done_at_rst = done;
            end
            if (!inst[32]) pmem_q.push_back(int'(inst[30:20]));
            if (!inst[19]) xmem_q.push_back(int'(inst[17:7]));
            if (inst[0]) begin
                n_load++;
                if (first_load < 0) first_load = c;
            end
            if (inst[2] && first_load < 0) n_l0wr_w++;
            if (inst[1]) n_exec++;
            if (inst[6]) begin
                n_ofifo++;
                rd_log[c] = 1'b1;
            end
            if (busy && !done) begin
                if (inst[35] !== 1'b1 || inst[33] !== acc || inst[5] || inst[4] ||
                    inst[31] !== 1'b1 || inst[18] !== 1'b1) bad++;
                if (!inst[32] && !inst[34]) bad++;
                if (!inst[19] && inst[34]) bad++;
                if (inst[1] && !(inst[2] && inst[3])) bad++;
            end else begin
                if (inst !== IDLE_W) bad++;
                if (done && !busy) bad++;
            end
        end
        start = 1'b0; reset = 1'b0; ofifo_valid = 1'b0;
    endtask

    task automatic check_pmem(input string tag, input int base);
        int got;
        check_eq({tag, " pmem count"}, pmem_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            got = (i < pmem_q.size()) ? pmem_q[i] : -1;
            check_eq($sformatf("%s A_pmem[%0d]", tag, i), got, (base + i) % 2048);
        end
    endtask

    task automatic check_xmem(input string tag, input int base, input int n);
        int got;
        check_eq({tag, " xmem count"}, xmem_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < xmem_q.size()) ? xmem_q[i] : -1;
            check_eq($sformatf("%s A_xmem[%0d]", tag, i), got, (base + i) % 2048);
        end
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        reset = 1'b1; start = 1'b0; w_base = '0; x_base = '0; n_act = '0;
        acc_en = 1'b0; ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset inst", inst, IDLE_W);
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic pass; start pulsed again in the FIN cycle must be ignored.
        run_pass(5, 100, 3, 1'b1, 0, 26, -1);
        check_pmem("c1", 5);
        check_eq("c1 wload cycles", first_load - 1, 9);
        check_eq("c1 wload l0_wr", n_l0wr_w, 8);
        check_eq("c1 load cycles", n_load, 8);
        check_xmem("c1", 100, 3);
        check_eq("c1 execute cycles", n_exec, 3);
        check_eq("c1 ofifo_rd cycles", n_ofifo, 3);
        check_eq("c1 ofifo_rd cycles pos", rd_log[25:23], 3'b111);
        check_eq("c1 done cycle", done_cyc, 26);
        check_eq("c1 done pulses", n_done, 1);
        check_eq("c1 busy after done", post_busy, 0);
        check_eq("c1 field rules", bad, 0);

        // Address wrap on both SRAMs.
        run_pass(2045, 2047, 2, 1'b0, 0, -1, -1);
        check_pmem("c2", 2045);
        check_xmem("c2", 2047, 2);
        check_eq("c2 done cycle", done_cyc, 24);
        check_eq("c2 field rules", bad, 0);

        // n_act = 0: GAP goes straight to FIN.
        run_pass(0, 50, 0, 1'b1, 0, -1, -1);
        check_pmem("c3", 0);
        check_xmem("c3", 50, 0);
        check_eq("c3 execute cycles", n_exec, 0);
        check_eq("c3 ofifo_rd cycles", n_ofifo, 0);
        check_eq("c3 done cycle", done_cyc, 19);
        check_eq("c3 done pulses", n_done, 1);
        check_eq("c3 field rules", bad, 0);

        // Gapped FIFO valid; start pulsed during KLOAD must be ignored.
        run_pass(10, 200, 3, 1'b0, 1, 12, -1);
        check_pmem("c4", 10);
        check_xmem("c4", 200, 3);
        check_eq("c4 ofifo_rd pattern", rd_log[28:23], 6'b011001);
        check_eq("c4 ofifo_rd cycles", n_ofifo, 3);
        check_eq("c4 done cycle", done_cyc, 28);
        check_eq("c4 done pulses", n_done, 1);
        check_eq("c4 busy after done", post_busy, 0);
        check_eq("c4 field rules", bad, 0);

        // Reset during the second EXEC cycle.
        run_pass(5, 100, 3, 1'b1, 0, -1, 20);
        check_eq("c5 inst after reset", inst_at_rst, IDLE_W);
        check_eq("c5 busy after reset", busy_at_rst, 0);
        check_eq("c5 done after reset", done_at_rst, 0);
        check_xmem("c5", 100, 2);
        check_eq("c5 execute cycles", n_exec, 1);
        check_eq("c5 done pulses", n_done, 0);
        check_eq("c5 busy after reset cnt", post_busy, 0);
        check_eq("c5 field rules", bad, 0);

        // Normal pass after the abort.
        run_pass(100, 2047, 1, 1'b1, 0, -1, -1);
        check_pmem("c6", 100);
        check_xmem("c6", 2047, 1);
        check_eq("c6 done cycle", done_cyc, 22);
        check_eq("c6 field rules", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
